// File: rtl/mac_mul_seq.sv
// mac_mul_seq: job sequencer for the 4-lane multiply block.
//
// Accepts a job descriptor (mode, beat count), forwards each operand beat to
// the multiplier through one register stage, and accumulates the returned
// products into an unsigned wrapping accumulator. When the job ends the sum
// is presented on the result port until it is consumed.
//
// Ports
//   clk, rst         rising-edge clock, asynchronous active-low reset
//   cfg_valid/ready  descriptor handshake; cfg_mode, cfg_len (0 = empty job)
//   in_valid/ready   operand beat handshake; in_a = {A3,A2,A1,A0}, in_b = B
//   mul_en/cfg/a/b   registered operands and latched mode to the multiplier
//   mul_c            combinational product back from the multiplier
//   out_valid/ready  result handshake; out_data = sum, out_ovf = sticky carry
//   dbg_state        current FSM state (IDLE=0, RUN=1, DRAIN=2, DONE=3)
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both 1. Ready never depends on valid. Once out_valid is 1, out_data and
// out_ovf hold until out_ready is seen. Each port's ready is 1 only in its
// own state (cfg in IDLE, in in RUN), so a descriptor and a result can
// never be exchanged in the same cycle.
//
// MAC_ACC_WIDTH must be >= MAC_INT_WIDTH.

module mac_mul_seq #(
  parameter int MAC_CONF_WIDTH = 3,
  parameter int MAC_MIN_WIDTH  = 8,
  parameter int MAC_INT_WIDTH  = 5 * MAC_MIN_WIDTH,
  parameter int MAC_ACC_WIDTH  = 48,
  parameter int LEN_WIDTH      = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cfg_valid,
  output logic                       cfg_ready,
  input  logic [MAC_CONF_WIDTH-1:0]  cfg_mode,
  input  logic [LEN_WIDTH-1:0]       cfg_len,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [4*MAC_MIN_WIDTH-1:0] in_a,
  input  logic [MAC_MIN_WIDTH-1:0]   in_b,
  output logic                       mul_en,
  output logic [MAC_CONF_WIDTH-1:0]  mul_cfg,
  output logic [4*MAC_MIN_WIDTH-1:0] mul_a,
  output logic [MAC_MIN_WIDTH-1:0]   mul_b,
  input  logic [MAC_INT_WIDTH-1:0]   mul_c,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [MAC_ACC_WIDTH-1:0]   out_data,
  output logic                       out_ovf,
  output logic [1:0]                 dbg_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                   state;
  logic [LEN_WIDTH-1:0]     cnt;
  logic                     s1_v;
  logic [MAC_ACC_WIDTH-1:0] acc;
  logic                     ovf;

  logic                     cfg_fire;
  logic                     in_fire;
  logic [MAC_ACC_WIDTH:0]   prod_ext;
  logic [MAC_ACC_WIDTH:0]   sum;

  assign cfg_fire = cfg_valid & cfg_ready;
  assign in_fire  = in_valid & in_ready;

  // One extra bit on the adder captures the carry out of the accumulator.
  assign prod_ext = {{(MAC_ACC_WIDTH + 1 - MAC_INT_WIDTH){1'b0}}, mul_c};
  assign sum      = {1'b0, acc} + prod_ext;

  assign mul_en    = s1_v;
  assign out_data  = acc;
  assign out_ovf   = ovf;
  assign dbg_state = state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      s1_v      <= 1'b0;
      acc       <= '0;
      ovf       <= 1'b0;
      cfg_ready <= 1'b0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      mul_cfg   <= '0;
      mul_a     <= '0;
      mul_b     <= '0;
    end else begin
      // Stage 2: the product of last cycle's registered beat lands in acc.
      // A cycle without a beat leaves s1_v low so nothing is added.
      if (s1_v) begin
        acc <= sum[MAC_ACC_WIDTH-1:0];
        if (sum[MAC_ACC_WIDTH]) ovf <= 1'b1;
      end
      s1_v <= 1'b0;

      case (state)
        IDLE: begin
          if (cfg_fire) begin
            mul_cfg   <= cfg_mode;
            cnt       <= cfg_len;
            acc       <= '0;
            ovf       <= 1'b0;
            cfg_ready <= 1'b0;
            if (cfg_len != '0) begin
              state    <= RUN;
              in_ready <= 1'b1;
            end else begin
              state     <= DONE;
              out_valid <= 1'b1;
            end
          end else begin
            // Ready rises on the first edge after reset is released.
            cfg_ready <= 1'b1;
          end
        end

        RUN: begin
          if (in_fire) begin
            mul_a <= in_a;
            mul_b <= in_b;
            s1_v  <= 1'b1;
            cnt   <= cnt - 1'b1;
            if (cnt == {{(LEN_WIDTH-1){1'b0}}, 1'b1}) begin
              state    <= DRAIN;
              in_ready <= 1'b0;
            end
          end
        end

        // The last beat's product is added during this cycle.
        DRAIN: begin
          state     <= DONE;
          out_valid <= 1'b1;
        end

        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            cfg_ready <= 1'b1;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/mac_mul_seq.md
# mac_mul_seq

Job sequencer for the 4-lane multiply block in the MAC datapath. It accepts a job descriptor (mode, beat count), streams operand beats into the multiplier through one register stage, and accumulates the products into a wide accumulator. When the job ends it presents the sum on a valid/ready result port. It sits between the operand-fetch logic and the multiply block and is the only driver of the multiplier's operand and config inputs.

## Interface
- MAC_CONF_WIDTH, 3, width of the mode field; bits [1:0] use `MAC_SINGLE/`MAC_DUAL/`MAC_QUAD from mac_const.vh
- MAC_MIN_WIDTH, 8, lane width
- MAC_INT_WIDTH, 5*MAC_MIN_WIDTH, multiplier result width
- MAC_ACC_WIDTH, 48, accumulator and result width; must be >= MAC_INT_WIDTH
- LEN_WIDTH, 8, beat-count width
- clk  in  1  clock; all logic is rising-edge
- rst  in  1  asynchronous, active-low reset (0 = reset asserted)
- cfg_valid  in  1  job descriptor valid
- cfg_ready  out  1  sequencer accepts a descriptor
- cfg_mode  in  MAC_CONF_WIDTH  multiplier mode for the job
- cfg_len  in  LEN_WIDTH  number of beats; 0 = empty job
- in_valid  in  1  operand beat valid
- in_ready  out  1  operand beat accepted
- in_a  in  4*MAC_MIN_WIDTH  packed {A3,A2,A1,A0}
- in_b  in  MAC_MIN_WIDTH  B operand
- mul_en  out  1  stage-1 operands valid
- mul_cfg  out  MAC_CONF_WIDTH  latched job mode
- mul_a  out  4*MAC_MIN_WIDTH  registered {A3,A2,A1,A0}
- mul_b  out  MAC_MIN_WIDTH  registered B
- mul_c  in  MAC_INT_WIDTH  combinational product from the multiplier
- out_valid  out  1  result valid
- out_ready  in  1  result consumed
- out_data  out  MAC_ACC_WIDTH  accumulated sum
- out_ovf  out  1  sticky: accumulator carry-out occurred during the job

## Operation
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE: cfg_ready=1. On cfg_valid, latch cfg_mode into mul_cfg, load the remaining-beat counter with cfg_len, clear acc and ovf. If cfg_len≠0 go to RUN; if cfg_len=0 go to DONE.
- RUN: in_ready=1. Each in_valid&in_ready beat loads mul_a/mul_b, sets s1_v and decrements the counter. The final beat (counter==1) moves the FSM to DRAIN. A cycle with no beat clears s1_v; mul_a/mul_b hold their values.
- DRAIN: in_ready=0; lasts one cycle, in which the final product is added; then DONE.
- Every cycle with s1_v=1: acc <= acc + zero-extend(mul_c). A carry out of MAC_ACC_WIDTH sets ovf, and ovf stays set until the next descriptor is accepted. Arithmetic is unsigned and wraps modulo 2^MAC_ACC_WIDTH.
- mul_en = s1_v.
- DONE: out_valid=1, out_data=acc, out_ovf=ovf. These values are held stable while out_ready=0. On out_ready the FSM returns to IDLE.
- cfg_ready=1 only in IDLE and in_ready=1 only in RUN. A descriptor cannot be accepted in the same cycle as a result handshake.
- Modes whose cfg[1:0] is outside SINGLE/DUAL/QUAD are passed through unchanged. The multiplier returns 0, so the job sums to 0 and completes normally.

## Timing
- Reset values: cfg_ready=0 while rst=0, then 1 in IDLE; in_ready=0, mul_en=0, mul_cfg=0, mul_a=0, mul_b=0, out_valid=0, out_data=0, out_ovf=0. acc, counter, s1_v and FSM are cleared to 0/IDLE.
- Reset asserted mid-job aborts the job immediately; no partial result is emitted.
- Beat accepted at edge t: mul_* are valid after t, and the product is in acc at edge t+1.
- Last beat accepted at edge t: out_valid rises after edge t+1.
- Full-throughput job of N beats: descriptor edge d, beats at d+1..d+N, out_valid after d+N+1.
- Empty job: descriptor at edge d, out_valid=1 with out_data=0 after d.
- Gaps in in_valid only stretch RUN; they never add spurious terms to acc.

## Test plan
- SINGLE, len 3, A3 lanes 2,3,4 with B 5,6,7, back-to-back beats -> out_data=56, out_ovf=0, out_valid one cycle after the last beat.
- QUAD, len 1, in_a=0x01020304, in_b=2 -> out_data=0x02040608. DUAL, len 2, {A3,A2}=0x0102 and 0x0001 with B=3 -> out_data=0x0309.
- MAC_ACC_WIDTH=40, QUAD, len 2, in_a=0xFFFFFFFF, in_b=0xFF -> out_data=0xFDFFFFFE02, out_ovf=1; the next job starts with out_ovf cleared.
- len 0 -> out_valid one cycle after the descriptor, out_data=0. Then hold out_ready=0 for 5 cycles with random in_valid -> out_data stable, cfg_ready=0, in_ready=0.
- SINGLE, len 4, in_valid toggled 1,0,0,1,1,0,1 with products 1,2,3,4 -> out_data=10; mul_en matches the accepted beats exactly.
- rst pulsed low after 2 of 5 beats -> all outputs take reset values asynchronously. A fresh len-1 job then produces only its own product.
